// File: rtl/meas_pkg.sv
// Shared types and helpers for the windowed max/min measurement scheduler.
package meas_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQ     = 2'd1,
      REPORT  = 2'd2,
      ADVANCE = 2'd3
   } state_t;

   // Returns {wrapped, ch}: next set bit above cur, else the lowest set bit with wrapped=1.
   // Passing cur = 4'hF yields the lowest set bit of the mask.
   function automatic logic [4:0] next_ch(input logic [15:0] mask, input logic [3:0] cur);
      logic       found;
      logic [3:0] ch;
      found = 1'b0;
      ch    = cur;
      for (int i = 15; i >= 0; i--) begin
         if (mask[i] && (i > int'(cur))) begin
            found = 1'b1;
            ch    = 4'(i);
         end
      end
      if (!found) begin
         for (int i = 15; i >= 0; i--) begin
            if (mask[i]) ch = 4'(i);
         end
      end
      return {~found, ch};
   endfunction

endpackage

// File: rtl/win_extreme.sv
// Signed running max/min accumulator; max/min outputs already include the current sample.
module win_extreme #(
   parameter int DATA_WIDTH = 12
) (
   input  logic                         clk_in,
   input  logic                         rst_n,
   input  logic                         clr_first,
   input  logic                         en,
   input  logic signed [DATA_WIDTH-1:0] sample,
   output logic signed [DATA_WIDTH-1:0] max,
   output logic signed [DATA_WIDTH-1:0] min
);

   logic signed [DATA_WIDTH-1:0] max_q, min_q;

   // First sample of a window seeds both extremes, so stale state never leaks in.
   always_comb begin
      max = max_q;
      min = min_q;
      if (clr_first) begin
         max = sample;
         min = sample;
      end else begin
         if (sample > max_q) max = sample;
         if (sample < min_q) min = sample;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         max_q <= '0;
         min_q <= '0;
      end else if (en) begin
         max_q <= max;
         min_q <= min;
      end
   end

endmodule

// File: rtl/meas_window_sched.sv
// Round-robin scheduler sharing one windowed max/min engine across CH_NUM sample channels.
module meas_window_sched
   import meas_pkg::*;
#(
   parameter int DATA_WIDTH   = 12,
   parameter int RANGE_WIDTH  = 10,
   parameter int CH_NUM       = 4,
   parameter int CH_SEL_WIDTH = 2
) (
   input  logic                         clk_in,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         stop,
   input  logic                         continuous,
   input  logic [RANGE_WIDTH-1:0]       range,
   input  logic [CH_NUM-1:0]            ch_mask,
   input  logic [CH_NUM*DATA_WIDTH-1:0] data_in,
   output logic                         busy,
   output logic [CH_SEL_WIDTH-1:0]      ch_sel,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [CH_SEL_WIDTH-1:0]      res_ch,
   output logic signed [DATA_WIDTH-1:0] res_max,
   output logic signed [DATA_WIDTH-1:0] res_min
);

   state_t                       state;
   logic [RANGE_WIDTH-1:0]       cnt, range_q, last;
   logic [CH_NUM-1:0]            mask_q;
   logic                         cont_q, stop_pend;
   logic [15:0]                  mask_cur, mask_new;
   logic [4:0]                   adv, first;
   logic signed [DATA_WIDTH-1:0] samp, ext_max, ext_min;

   always_comb begin
      mask_cur = '0;
      mask_new = '0;
      mask_cur[CH_NUM-1:0] = mask_q;
      mask_new[CH_NUM-1:0] = ch_mask;
   end

   assign adv   = next_ch(mask_cur, 4'(ch_sel));
   assign first = next_ch(mask_new, 4'hF);
   // A zero window length behaves as a one-sample window.
   assign last  = (range_q == '0) ? '0 : range_q - 1'b1;
   assign samp  = data_in[ch_sel*DATA_WIDTH +: DATA_WIDTH];

   assign busy      = (state != IDLE);
   assign res_valid = (state == REPORT);

   win_extreme #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .clr_first (cnt == '0),
      .en        (state == ACQ),
      .sample    (samp),
      .max       (ext_max),
      .min       (ext_min)
   );

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ch_sel    <= '0;
         cnt       <= '0;
         range_q   <= '0;
         mask_q    <= '0;
         cont_q    <= 1'b0;
         stop_pend <= 1'b0;
         res_ch    <= '0;
         res_max   <= '0;
         res_min   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !stop && (ch_mask != '0)) begin
                  range_q   <= range;
                  mask_q    <= ch_mask;
                  cont_q    <= continuous;
                  stop_pend <= 1'b0;
                  cnt       <= '0;
                  ch_sel    <= CH_SEL_WIDTH'(first[3:0]);
                  state     <= ACQ;
               end
            end
            ACQ: begin
               if (stop) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else if (cnt == last) begin
                  res_ch  <= ch_sel;
                  res_max <= ext_max;
                  res_min <= ext_min;
                  state   <= REPORT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            REPORT: begin
               if (stop)      stop_pend <= 1'b1;
               if (res_ready) state     <= ADVANCE;
            end
            ADVANCE: begin
               ch_sel <= CH_SEL_WIDTH'(adv[3:0]);
               cnt    <= '0;
               // A stop landing in this cycle counts like a pending one.
               if ((adv[4] && !cont_q) || stop_pend || stop) begin
                  stop_pend <= 1'b0;
                  state     <= IDLE;
               end else begin
                  state <= ACQ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_meas_window_sched.sv
// Directed bench for meas_window_sched with hand-computed window results.
module tb_meas_window_sched;

   localparam int DW = 12;
   localparam int RW = 10;
   localparam int CN = 4;
   localparam int CW = 2;

   logic                 clk_in = 1'b0;
   logic                 rst_n;
   logic                 start, stop, continuous, res_ready;
   logic [RW-1:0]        range;
   logic [CN-1:0]        ch_mask;
   logic [CN*DW-1:0]     data_in;
   logic                 busy, res_valid;
   logic [CW-1:0]        ch_sel, res_ch;
   logic signed [DW-1:0] res_max, res_min;

   int n_vec = 0;
   int n_err = 0;

   meas_window_sched #(.DATA_WIDTH(DW), .RANGE_WIDTH(RW), .CH_NUM(CN), .CH_SEL_WIDTH(CW)) dut (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .continuous (continuous),
      .range      (range),
      .ch_mask    (ch_mask),
      .data_in    (data_in),
      .busy       (busy),
      .ch_sel     (ch_sel),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_ch     (res_ch),
      .res_max    (res_max),
      .res_min    (res_min)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic set_ch(input int c, input int v);
      data_in[c*DW +: DW] = DW'(v);
   endtask

   task automatic chk_res(input string tag, input int ch, input int mx, input int mn);
      chk({tag, "_valid"}, int'(res_valid), 1);
      chk({tag, "_ch"},    int'(res_ch),    ch);
      chk({tag, "_max"},   int'(res_max),   mx);
      chk({tag, "_min"},   int'(res_min),   mn);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"},  int'(busy),      0);
      chk({tag, "_chsel"}, int'(ch_sel),    0);
      chk({tag, "_valid"}, int'(res_valid), 0);
      chk({tag, "_resch"}, int'(res_ch),    0);
      chk({tag, "_max"},   int'(res_max),   0);
      chk({tag, "_min"},   int'(res_min),   0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0; res_ready = 1'b1;
      range = '0; ch_mask = '0; data_in = '0;
      tick(); tick();
      rst_n = 1'b1;
      chk_zero("reset");

      // Single pass over ch0 and ch2, range 4; range change mid-pass is ignored
      ch_mask = 4'b0101; range = 10'd4; set_ch(2, 5);
      start = 1'b1; tick(); start = 1'b0; range = 10'd7;
      chk("sp_chsel0", int'(ch_sel), 0);
      set_ch(0, -3); tick();
      set_ch(0, 7);  tick();
      set_ch(0, 2);  tick();
      chk("sp_novalid", int'(res_valid), 0);
      set_ch(0, -8); tick();
      chk_res("sp_ch0", 0, 7, -8);
      tick();
      chk("sp_adv_valid", int'(res_valid), 0);
      chk("sp_persist", int'(res_max), 7);
      tick();
      chk("sp_chsel2", int'(ch_sel), 2);
      repeat (4) tick();
      chk_res("sp_ch2", 2, 5, 5);
      tick(); tick();
      chk("sp_idle", int'(busy), 0);

      // range 0 acts as 1, then backpressure for 10 cycles
      ch_mask = 4'b0010; range = 10'd0; set_ch(1, -2048); res_ready = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      chk("r0_early", int'(res_valid), 0);
      tick();
      chk_res("r0", 1, -2048, -2048);
      for (int i = 0; i < 10; i++) begin
         set_ch(1, 100 + i); tick();
         chk("bp_valid", int'(res_valid), 1);
         chk("bp_max",   int'(res_max),   -2048);
         chk("bp_min",   int'(res_min),   -2048);
         chk("bp_chsel", int'(ch_sel),    1);
      end
      res_ready = 1'b1; tick();
      chk("bp_adv", int'(res_valid), 0);
      tick();
      chk("bp_idle", int'(busy), 0);

      // Continuous single-channel wrap, then stop during REPORT
      ch_mask = 4'b1000; range = 10'd3; continuous = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      set_ch(3, 1); tick();
      set_ch(3, 2); tick();
      set_ch(3, 3); tick();
      chk_res("ct_p1", 3, 3, 1);
      tick();
      chk("ct_adv", int'(res_valid), 0);
      tick();
      chk("ct_rearm", int'(busy), 1);
      set_ch(3, -5); tick();
      set_ch(3, 0);  tick();
      chk("ct_gap", int'(res_valid), 0);
      set_ch(3, 4);  tick();
      chk_res("ct_p2", 3, 4, -5);
      res_ready = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
      chk("sr_hold", int'(res_valid), 1);
      chk("sr_max",  int'(res_max),   4);
      res_ready = 1'b1; tick(); tick();
      chk("sr_idle",  int'(busy),      0);
      chk("sr_valid", int'(res_valid), 0);
      continuous = 1'b0;

      // Stop mid-ACQ: no result, previous result persists
      ch_mask = 4'b0001; range = 10'd8; set_ch(0, 50);
      start = 1'b1; tick(); start = 1'b0;
      repeat (3) tick();
      stop = 1'b1; tick(); stop = 1'b0;
      chk("sa_idle",  int'(busy),      0);
      chk("sa_valid", int'(res_valid), 0);
      chk("sa_keep",  int'(res_max),   4);
      repeat (8) tick();
      chk("sa_noval", int'(res_valid), 0);

      // start+stop together, and start with empty mask
      start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      chk("ss_idle", int'(busy), 0);
      ch_mask = 4'b0000; start = 1'b1; tick(); start = 1'b0;
      chk("m0_idle", int'(busy), 0);

      // Async reset mid-ACQ, then fresh window
      ch_mask = 4'b0100; range = 10'd4; set_ch(2, 1000);
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      #2 rst_n = 1'b0;
      #1 chk_zero("arst");
      tick();
      rst_n = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      set_ch(2, -1); tick();
      set_ch(2, -2); tick();
      set_ch(2, -3); tick();
      set_ch(2, -4); tick();
      chk_res("fresh", 2, -1, -4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
